// File: rtl/vending_pkg.sv
// Shared types and default tuning constants for the vending machine front-end.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    JAM     = 2'd2,
    LOCKOUT = 2'd3
  } coin_state_t;

  localparam int COIN_MIN_W       = 4;
  localparam int COIN_MAX_W       = 16;
  localparam int COIN_GAP         = 8;
  localparam int COIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser chain of configurable depth for an asynchronous input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front-end: measures each synchronised sensor pulse and issues one
// accept or reject pulse per coin event, with jam detection and a bounce lockout.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int SYNC_STAGES = COIN_SYNC_STAGES,
  parameter int MIN_W       = COIN_MIN_W,
  parameter int MAX_W       = COIN_MAX_W,
  parameter int GAP         = COIN_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       enable,
  output logic       coin_in,
  output logic       coin_reject,
  output logic       jam,
  output logic       busy,
  output logic [7:0] accept_count
);

  localparam int WW = $clog2(MAX_W + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [WW-1:0] MIN_WV = WW'(MIN_W);
  localparam logic [WW-1:0] MAX_WV = WW'(MAX_W);
  localparam logic [GW-1:0] GAP_V  = GW'(GAP);

  logic          s;
  logic          en_q;
  logic [WW-1:0] width;
  logic [GW-1:0] gap;
  coin_state_t   state;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (coin_sense),
    .q   (s)
  );

  // enable is latched once at pulse onset so a change mid-coin cannot flip the verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      width        <= '0;
      gap          <= '0;
      en_q         <= 1'b0;
      coin_in      <= 1'b0;
      coin_reject  <= 1'b0;
      jam          <= 1'b0;
      busy         <= 1'b0;
      accept_count <= '0;
    end else begin
      coin_in     <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= MEASURE;
            width <= WW'(1);
            en_q  <= enable;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (s) begin
            if (width < MAX_WV) begin
              width <= width + 1'b1;
            end else begin
              coin_reject <= 1'b1;
              jam         <= 1'b1;
              state       <= JAM;
            end
          end else begin
            if (en_q && (width >= MIN_WV) && (width <= MAX_WV)) begin
              coin_in      <= 1'b1;
              accept_count <= accept_count + 8'd1;
            end else begin
              coin_reject <= 1'b1;
            end
            state <= LOCKOUT;
            gap   <= GAP_V;
          end
        end
        JAM: begin
          if (!s) begin
            jam   <= 1'b0;
            state <= LOCKOUT;
            gap   <= GAP_V;
          end
        end
        LOCKOUT: begin
          gap <= gap - 1'b1;
          if (gap == GW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: table of pulse vectors plus hand-built
// sequences for lockout bounce, mid-measurement reset and counter wrap.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_sense;
  logic       enable;
  logic       coin_in;
  logic       coin_reject;
  logic       jam;
  logic       busy;
  logic [7:0] accept_count;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [7:0] exp_count = 8'd0;

  typedef struct {
    int n;
    bit en0;
    bit en1;
    int exp_ins;
    int exp_rejs;
    int exp_evt_c;
    int exp_jam;
    int exp_fall_c;
  } vec_t;

  typedef struct {
    int ins;
    int rejs;
    int overlap;
    int jam_cycles;
    int evt_c;
    int rise_c;
    int fall_c;
  } result_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk          (clk),
    .rst          (rst),
    .coin_sense   (coin_sense),
    .enable       (enable),
    .coin_in      (coin_in),
    .coin_reject  (coin_reject),
    .jam          (jam),
    .busy         (busy),
    .accept_count (accept_count)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Cycle index c counts posedges from the start of the pulse; outputs are
  // sampled on the following negedge.
  task automatic applyStimulus(input int n, input bit en0, input bit en1,
                               input int b_start, input int b_len, output result_t r);
    r = '{default: 0};
    r.evt_c  = -1;
    r.rise_c = -1;
    r.fall_c = -1;
    for (int c = 0; c < n + 30; c++) begin
      coin_sense = (c < n) || (c >= b_start && c < b_start + b_len);
      enable     = (c < n / 2) ? en0 : en1;
      @(posedge clk);
      @(negedge clk);
      if (coin_in) r.ins++;
      if (coin_reject) r.rejs++;
      if (coin_in && coin_reject) r.overlap++;
      if ((coin_in || coin_reject) && r.evt_c < 0) r.evt_c = c;
      if (jam) r.jam_cycles++;
      if (busy && r.rise_c < 0) r.rise_c = c;
      if (!busy && r.rise_c >= 0 && r.fall_c < 0) r.fall_c = c;
    end
    coin_sense = 1'b0;
    enable     = 1'b1;
  endtask

  initial begin
    result_t r;
    int pulses;

    vecs[0] = '{6,  1, 1, 1, 0, 8,  0,  16};
    vecs[1] = '{2,  1, 1, 0, 1, 4,  0,  12};
    vecs[2] = '{4,  1, 1, 1, 0, 6,  0,  14};
    vecs[3] = '{16, 1, 1, 1, 0, 18, 0,  26};
    vecs[4] = '{1,  1, 1, 0, 1, 3,  0,  11};
    vecs[5] = '{3,  1, 1, 0, 1, 5,  0,  13};
    vecs[6] = '{30, 1, 1, 0, 1, 18, 14, 40};
    vecs[7] = '{17, 1, 1, 0, 1, 18, 1,  27};
    vecs[8] = '{6,  0, 1, 0, 1, 8,  0,  16};
    vecs[9] = '{6,  1, 0, 1, 0, 8,  0,  16};

    rst        = 1'b1;
    coin_sense = 1'b0;
    enable     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset coin_in", int'(coin_in), 0);
    checkOutput("reset coin_reject", int'(coin_reject), 0);
    checkOutput("reset jam", int'(jam), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset accept_count", int'(accept_count), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].n, vecs[i].en0, vecs[i].en1, 0, 0, r);
      exp_count += 8'(vecs[i].exp_ins);
      $display("[TB] vector %0d: width %0d", i, vecs[i].n);
      checkOutput($sformatf("v%0d coin_in count", i), r.ins, vecs[i].exp_ins);
      checkOutput($sformatf("v%0d reject count", i), r.rejs, vecs[i].exp_rejs);
      checkOutput($sformatf("v%0d overlap", i), r.overlap, 0);
      checkOutput($sformatf("v%0d event cycle", i), r.evt_c, vecs[i].exp_evt_c);
      checkOutput($sformatf("v%0d jam cycles", i), r.jam_cycles, vecs[i].exp_jam);
      checkOutput($sformatf("v%0d busy rise", i), r.rise_c, 2);
      checkOutput($sformatf("v%0d busy fall", i), r.fall_c, vecs[i].exp_fall_c);
      checkOutput($sformatf("v%0d accept_count", i), int'(accept_count), int'(exp_count));
    end

    // Bounce landing entirely inside the lockout window must be invisible
    applyStimulus(6, 1, 1, 10, 3, r);
    exp_count += 8'd1;
    checkOutput("bounce coin_in count", r.ins, 1);
    checkOutput("bounce reject count", r.rejs, 0);
    checkOutput("bounce busy fall", r.fall_c, 16);
    applyStimulus(6, 1, 1, 0, 0, r);
    exp_count += 8'd1;
    checkOutput("post-bounce coin_in count", r.ins, 1);
    checkOutput("post-bounce accept_count", int'(accept_count), int'(exp_count));

    // Reset while measuring at width 5 drops the pending coin silently
    coin_sense = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("pre-reset busy", int'(busy), 1);
    rst        = 1'b1;
    coin_sense = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_count = 8'd0;
    checkOutput("mid reset busy", int'(busy), 0);
    checkOutput("mid reset coin_in", int'(coin_in), 0);
    checkOutput("mid reset coin_reject", int'(coin_reject), 0);
    checkOutput("mid reset accept_count", int'(accept_count), int'(exp_count));
    rst    = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (coin_in || coin_reject || busy) pulses++;
    end
    checkOutput("post reset activity", pulses, 0);

    // Counter wrap after 256 accepted coins
    for (int k = 0; k < 255; k++) begin
      applyStimulus(4, 1, 1, 0, 0, r);
      exp_count += 8'(r.ins);
    end
    checkOutput("accept_count at 255", int'(accept_count), 255);
    applyStimulus(4, 1, 1, 0, 0, r);
    exp_count += 8'd1;
    checkOutput("wrap coin_in count", r.ins, 1);
    checkOutput("accept_count wrapped", int'(accept_count), int'(exp_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
